// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int STARVE_MAX_DEFAULT = 4;

    // Width needed to hold 0..starve_max inclusive.
    function automatic int starve_w(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction

    localparam int STARVE_W = starve_w(STARVE_MAX_DEFAULT);

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable down-counter timing the fixed memory access latency
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : load LAT-1 (start of an access)
//   en         : decrement while nonzero
//   zero       : counter is at zero (last access cycle)
module mem_lat_counter #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] INIT = CW'(LAT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= INIT;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data ports
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   if_req/if_addr             : fetch request (held until if_ready) and PC
//   if_rdata/if_ready          : fetched word and one-cycle completion pulse
//   d_req/d_rw/d_size/d_se     : data request (held until d_ready), write flag, size, sign extend
//   d_addr/d_wdata             : data address and store data
//   d_rdata/d_ready            : load data and one-cycle completion pulse
//   mem_*                      : registered memory command, mem_rdata valid in last access cycle
//   stall_if/stall_mem         : combinational req & ~ready for the hazard unit
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 9,
    parameter int DW         = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [1:0]    d_size,
    input  logic          d_se,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [1:0]    mem_size,
    output logic          mem_se,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int SW = starve_w(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t    state, next_state;
    logic [SW-1:0] starve_cnt;
    logic          any_req;
    logic          gnt;
    logic          lat_zero;
    logic          cnt_load;
    logic          cnt_en;

    assign any_req = if_req | d_req;

    // Data wins by default; fetch only wins alone or once data has won
    // STARVE_MAX contended arbitrations in a row.
    assign gnt = (if_req && (!d_req || (starve_cnt == STARVE_LIM))) ? GNT_IF : GNT_D;

    mem_lat_counter #(
        .LAT(LAT)
    ) u_lat (
        .clk  (clk),
        .reset(reset),
        .load (cnt_load),
        .en   (cnt_en),
        .zero (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    cnt_load   = 1'b1;
                    next_state = (gnt == GNT_IF) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I: begin
                cnt_en = 1'b1;
                if (lat_zero) begin
                    next_state = DONE_I;
                end
            end
            BUSY_D: begin
                cnt_en = 1'b1;
                if (lat_zero) begin
                    next_state = DONE_D;
                end
            end
            DONE_I:  next_state = IDLE;
            DONE_D:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_size   <= '0;
            mem_se     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            // Ready pulses last exactly the DONE cycle.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_en <= 1'b1;
                        if (gnt == GNT_IF) begin
                            mem_addr   <= if_addr;
                            mem_rw     <= 1'b0;
                            mem_size   <= SIZE_WORD;
                            mem_se     <= 1'b0;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_rw    <= d_rw;
                            mem_size  <= d_size;
                            mem_se    <= d_se;
                            mem_wdata <= d_wdata;
                            if (if_req && (starve_cnt != STARVE_LIM)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                BUSY_I: begin
                    if (lat_zero) begin
                        mem_en   <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (lat_zero) begin
                        mem_en   <= 1'b0;
                        d_rdata  <= mem_rdata;
                        d_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (LAT=1 and LAT=3 instances)
module tb_mem_port_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req    [2];
    logic [AW-1:0] if_addr   [2];
    logic [DW-1:0] if_rdata  [2];
    logic          if_ready  [2];
    logic          d_req     [2];
    logic          d_rw      [2];
    logic [1:0]    d_size    [2];
    logic          d_se      [2];
    logic [AW-1:0] d_addr    [2];
    logic [DW-1:0] d_wdata   [2];
    logic [DW-1:0] d_rdata   [2];
    logic          d_ready   [2];
    logic          mem_en    [2];
    logic          mem_rw    [2];
    logic [1:0]    mem_size  [2];
    logic          mem_se    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    wire  [DW-1:0] mem_rdata [2];
    logic          stall_if  [2];
    logic          stall_mem [2];

    logic [DW-1:0] ram [0:511];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign mem_rdata[g] = ram[mem_addr[g]];
        mem_port_arbiter #(
            .AW(AW), .DW(DW), .LAT((g == 0) ? 1 : 3), .STARVE_MAX(SMAX)
        ) dut (
            .clk(clk), .reset(reset),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
            .d_req(d_req[g]), .d_rw(d_rw[g]), .d_size(d_size[g]), .d_se(d_se[g]),
            .d_addr(d_addr[g]), .d_wdata(d_wdata[g]), .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
            .mem_en(mem_en[g]), .mem_rw(mem_rw[g]), .mem_size(mem_size[g]), .mem_se(mem_se[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .stall_if(stall_if[g]), .stall_mem(stall_mem[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level reference: one outstanding access per instance, timed from its grant cycle.
    bit            m_busy     [2];
    int            m_start    [2];
    bit            m_gnt_d    [2];
    logic [AW-1:0] m_addr     [2];
    logic          m_rw       [2];
    logic [1:0]    m_size     [2];
    logic          m_se       [2];
    logic [DW-1:0] m_wdata    [2];
    int            m_starve   [2];
    logic [DW-1:0] m_if_rdata [2];
    logic [DW-1:0] m_d_rdata  [2];
    bit            e_if_ready [2];
    bit            e_d_ready  [2];

    // Random requester agents.
    int f_pct [2];
    int d_pct [2];
    int wr_pct;
    int wd_pct;
    int rst_pm;
    bit f_pend [2];
    bit d_pend [2];
    bit last_reset;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_compare(input int k);
        int rel;
        int lat;
        bit e_en;
        lat = lat_of(k);
        rel = cyc - m_start[k];
        e_en = m_busy[k] && rel >= 1 && rel <= lat;
        e_if_ready[k] = m_busy[k] && !m_gnt_d[k] && rel == lat + 1;
        e_d_ready[k]  = m_busy[k] &&  m_gnt_d[k] && rel == lat + 1;
        checks++;
        if (mem_en[k] !== e_en) begin
            errors++; $display("FAIL model_mem_en k=%0d cyc=%0d got=%b exp=%b", k, cyc, mem_en[k], e_en);
        end
        checks++;
        if (if_ready[k] !== e_if_ready[k] || d_ready[k] !== e_d_ready[k]) begin
            errors++; $display("FAIL model_ready k=%0d cyc=%0d got=%b%b exp=%b%b", k, cyc,
                               if_ready[k], d_ready[k], e_if_ready[k], e_d_ready[k]);
        end
        checks++;
        if (if_rdata[k] !== m_if_rdata[k] || d_rdata[k] !== m_d_rdata[k]) begin
            errors++; $display("FAIL model_rdata k=%0d cyc=%0d got=%h/%h exp=%h/%h", k, cyc,
                               if_rdata[k], d_rdata[k], m_if_rdata[k], m_d_rdata[k]);
        end
        checks++;
        if (stall_if[k] !== (if_req[k] && !e_if_ready[k]) || stall_mem[k] !== (d_req[k] && !e_d_ready[k])) begin
            errors++; $display("FAIL model_stall k=%0d cyc=%0d got=%b%b exp=%b%b", k, cyc, stall_if[k],
                               stall_mem[k], (if_req[k] && !e_if_ready[k]), (d_req[k] && !e_d_ready[k]));
        end
        if (e_en) begin
            checks++;
            if ({mem_addr[k], mem_rw[k], mem_size[k]} !== {m_addr[k], m_rw[k], m_size[k]}) begin
                errors++; $display("FAIL model_mem_cmd k=%0d cyc=%0d got=%h/%b/%b exp=%h/%b/%b", k, cyc,
                                   mem_addr[k], mem_rw[k], mem_size[k], m_addr[k], m_rw[k], m_size[k]);
            end
            if (m_gnt_d[k]) begin
                checks++;
                if ({mem_se[k], mem_wdata[k]} !== {m_se[k], m_wdata[k]}) begin
                    errors++; $display("FAIL model_mem_wdata k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc,
                                       mem_se[k], mem_wdata[k], m_se[k], m_wdata[k]);
                end
            end
        end
    endtask

    task automatic model_edge(input int k);
        int rel;
        int lat;
        bit fw;
        lat = lat_of(k);
        rel = cyc - m_start[k];
        if (reset) begin
            m_busy[k] = 0; m_starve[k] = 0; m_if_rdata[k] = '0; m_d_rdata[k] = '0;
        end else if (m_busy[k]) begin
            if (rel == lat) begin
                if (m_gnt_d[k]) m_d_rdata[k] = ram[m_addr[k]];
                else            m_if_rdata[k] = ram[m_addr[k]];
            end
            if (rel == lat + 1) m_busy[k] = 0;
        end else if (if_req[k] || d_req[k]) begin
            fw = if_req[k] && (!d_req[k] || m_starve[k] == SMAX);
            if (fw) m_starve[k] = 0;
            else if (if_req[k] && m_starve[k] < SMAX) m_starve[k] = m_starve[k] + 1;
            m_busy[k] = 1; m_start[k] = cyc; m_gnt_d[k] = !fw;
            if (fw) begin
                m_addr[k] = if_addr[k]; m_rw[k] = 1'b0; m_size[k] = 2'b10;
                m_se[k] = 1'b0; m_wdata[k] = '0;
            end else begin
                m_addr[k] = d_addr[k]; m_rw[k] = d_rw[k]; m_size[k] = d_size[k];
                m_se[k] = d_se[k]; m_wdata[k] = d_wdata[k];
            end
        end
    endtask

    task automatic drive_agents(input int k);
        if (last_reset) begin f_pend[k] = 0; d_pend[k] = 0; end
        if (f_pend[k] && e_if_ready[k]) f_pend[k] = 0;
        if (d_pend[k] && e_d_ready[k])  d_pend[k] = 0;
        if (!f_pend[k]) begin
            if ($urandom_range(99) < f_pct[k]) begin
                f_pend[k] = 1; if_req[k] = 1'b1; if_addr[k] = AW'($urandom_range(511));
            end else begin
                if_req[k] = 1'b0;
            end
        end
        if (d_pend[k]) begin
            if (d_req[k] && m_busy[k] && m_gnt_d[k] && $urandom_range(99) < wd_pct) d_req[k] = 1'b0;
        end else if ($urandom_range(99) < d_pct[k]) begin
            d_pend[k] = 1; d_req[k] = 1'b1;
            d_rw[k]    = ($urandom_range(99) < wr_pct);
            d_size[k]  = 2'($urandom_range(3));
            d_se[k]    = 1'($urandom_range(1));
            d_addr[k]  = AW'($urandom_range(511));
            d_wdata[k] = $urandom;
        end else begin
            d_req[k] = 1'b0;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_compare(0);
        model_compare(1);
    endtask

    task automatic advance(input bit auto_drive);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        last_reset = reset;
        #1;
        cyc++;
        if (auto_drive) begin
            reset = ($urandom_range(999) < rst_pm);
            drive_agents(0);
            drive_agents(1);
        end
    endtask

    task automatic run(input int n, input bit auto_drive);
        repeat (n) begin
            at_neg();
            advance(auto_drive);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        advance(0);
        advance(0);
        at_neg();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({mem_en[k], mem_rw[k], mem_size[k], mem_se[k], mem_addr[k], mem_wdata[k],
                 if_rdata[k], d_rdata[k], if_ready[k], d_ready[k], stall_if[k], stall_mem[k]} !== '0) begin
                errors++; $display("FAIL reset_outputs k=%0d got en=%b addr=%h ifr=%h dr=%h rdy=%b%b exp=0", k,
                                   mem_en[k], mem_addr[k], if_rdata[k], d_rdata[k], if_ready[k], d_ready[k]);
            end
        end
        advance(0);
        reset = 1'b0;
    endtask

    task automatic test_lone_fetch();
        ram[9'h004] = 32'hA000_0001;
        if_req[0] = 1'b1; if_addr[0] = 9'h004;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            checks++;
            if (stall_if[0] !== (c <= 1)) begin
                errors++; $display("FAIL lone_fetch_stall cyc=%0d got=%b exp=%b", c, stall_if[0], (c <= 1));
            end
            checks++;
            if (mem_en[0] !== (c == 1)) begin
                errors++; $display("FAIL lone_fetch_mem_en cyc=%0d got=%b exp=%b", c, mem_en[0], (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (mem_addr[0] !== 9'h004 || mem_rw[0] !== 1'b0) begin
                    errors++; $display("FAIL lone_fetch_cmd got=%h/%b exp=004/0", mem_addr[0], mem_rw[0]);
                end
            end
            if (c == 2) begin
                checks++;
                if (if_ready[0] !== 1'b1 || if_rdata[0] !== 32'hA000_0001) begin
                    errors++; $display("FAIL lone_fetch_ready got=%b/%h exp=1/a0000001", if_ready[0], if_rdata[0]);
                end
            end
            advance(0);
            if (c == 2) if_req[0] = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] fw_word;
        fw_word = $urandom;
        ram[9'h040] = fw_word;
        if_req[0] = 1'b1; if_addr[0] = 9'h040;
        d_req[0] = 1'b1; d_rw[0] = 1'b1; d_addr[0] = 9'h010; d_wdata[0] = 32'hDEAD_BEEF;
        d_size[0] = 2'b10; d_se[0] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            at_neg();
            checks++;
            if (stall_if[0] !== (c <= 4)) begin
                errors++; $display("FAIL contention_stall_if cyc=%0d got=%b exp=%b", c, stall_if[0], (c <= 4));
            end
            if (c == 1) begin
                checks++;
                if (mem_en[0] !== 1'b1 || mem_rw[0] !== 1'b1 || mem_addr[0] !== 9'h010 || mem_wdata[0] !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL contention_data_first got=%b/%b/%h/%h exp=1/1/010/deadbeef",
                                       mem_en[0], mem_rw[0], mem_addr[0], mem_wdata[0]);
                end
            end
            checks++;
            if (d_ready[0] !== (c == 2)) begin
                errors++; $display("FAIL contention_d_ready cyc=%0d got=%b exp=%b", c, d_ready[0], (c == 2));
            end
            if (c == 4) begin
                checks++;
                if (mem_en[0] !== 1'b1 || mem_rw[0] !== 1'b0 || mem_addr[0] !== 9'h040) begin
                    errors++; $display("FAIL contention_fetch_grant got=%b/%b/%h exp=1/0/040", mem_en[0], mem_rw[0], mem_addr[0]);
                end
            end
            checks++;
            if (if_ready[0] !== (c == 5)) begin
                errors++; $display("FAIL contention_if_ready cyc=%0d got=%b exp=%b", c, if_ready[0], (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (if_rdata[0] !== fw_word) begin
                    errors++; $display("FAIL contention_if_rdata got=%h exp=%h", if_rdata[0], fw_word);
                end
            end
            advance(0);
            if (c == 2) d_req[0] = 1'b0;
            if (c == 5) if_req[0] = 1'b0;
        end
    endtask

    task automatic test_starvation();
        int nev;
        int budget;
        bit exp_f;
        f_pct[0] = 100; d_pct[0] = 100; f_pct[1] = 0; d_pct[1] = 0;
        wr_pct = 50; wd_pct = 0; rst_pm = 0;
        drive_agents(0);
        drive_agents(1);
        nev = 0;
        budget = 300;
        while (nev < 10 && budget > 0) begin
            at_neg();
            if (if_ready[0] === 1'b1 || d_ready[0] === 1'b1) begin
                exp_f = (nev % 5 == 4);
                checks++;
                if (if_ready[0] !== exp_f || d_ready[0] !== !exp_f) begin
                    errors++; $display("FAIL starvation_order event=%0d got if=%b d=%b exp if=%b d=%b",
                                       nev, if_ready[0], d_ready[0], exp_f, !exp_f);
                end
                nev++;
            end
            advance(1);
            budget--;
        end
        if (nev < 10) begin
            checks++; errors++;
            $display("FAIL starvation_timeout got=%0d events exp=10", nev);
        end
        f_pct[0] = 0; d_pct[0] = 0;
        run(20, 1);
    endtask

    task automatic test_latency3();
        ram[9'h020] = 32'h1234_5678;
        d_req[1] = 1'b1; d_rw[1] = 1'b0; d_addr[1] = 9'h020; d_size[1] = 2'b10; d_se[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            checks++;
            if (mem_en[1] !== (c >= 1 && c <= 3)) begin
                errors++; $display("FAIL lat3_mem_en cyc=%0d got=%b exp=%b", c, mem_en[1], (c >= 1 && c <= 3));
            end
            checks++;
            if (d_ready[1] !== (c == 4)) begin
                errors++; $display("FAIL lat3_d_ready cyc=%0d got=%b exp=%b", c, d_ready[1], (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (d_rdata[1] !== 32'h1234_5678) begin
                    errors++; $display("FAIL lat3_d_rdata got=%h exp=12345678", d_rdata[1]);
                end
            end
            advance(0);
            if (c == 4) d_req[1] = 1'b0;
        end
    endtask

    task automatic test_withdraw();
        d_req[1] = 1'b1; d_rw[1] = 1'b1; d_addr[1] = 9'h030; d_wdata[1] = $urandom;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            checks++;
            if (mem_en[1] !== (c >= 1 && c <= 3)) begin
                errors++; $display("FAIL withdraw_mem_en cyc=%0d got=%b exp=%b", c, mem_en[1], (c >= 1 && c <= 3));
            end
            checks++;
            if (d_ready[1] !== (c == 4) || stall_mem[1] !== (c == 0)) begin
                errors++; $display("FAIL withdraw_ready_stall cyc=%0d got=%b/%b exp=%b/%b", c,
                                   d_ready[1], stall_mem[1], (c == 4), (c == 0));
            end
            advance(0);
            if (c == 0) d_req[1] = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        d_req[1] = 1'b1; d_rw[1] = 1'b0; d_addr[1] = 9'h021;
        for (int c = 0; c < 10; c++) begin
            at_neg();
            checks++;
            if (mem_en[1] !== (c == 1 || c == 2)) begin
                errors++; $display("FAIL abort_mem_en cyc=%0d got=%b exp=%b", c, mem_en[1], (c == 1 || c == 2));
            end
            checks++;
            if (d_ready[1] !== 1'b0) begin
                errors++; $display("FAIL abort_no_ready cyc=%0d got=%b exp=0", c, d_ready[1]);
            end
            advance(0);
            if (c == 1) reset = 1'b1;
            if (c == 2) begin reset = 1'b0; d_req[1] = 1'b0; end
        end
    endtask

    task automatic test_random();
        f_pct[0] = 40; d_pct[0] = 50; f_pct[1] = 45; d_pct[1] = 45;
        wr_pct = 50; wd_pct = 20; rst_pm = 5;
        run(3000, 1);
        f_pct[0] = 0; d_pct[0] = 0; f_pct[1] = 0; d_pct[1] = 0; rst_pm = 0;
        run(30, 1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = $urandom;
        reset = 1'b1;
        last_reset = 1'b0;
        wr_pct = 0; wd_pct = 0; rst_pm = 0;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_rw[k] = 1'b0; d_size[k] = '0; d_se[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0;
            m_busy[k] = 0; m_start[k] = 0; m_gnt_d[k] = 0; m_starve[k] = 0;
            m_addr[k] = '0; m_rw[k] = 1'b0; m_size[k] = '0; m_se[k] = 1'b0; m_wdata[k] = '0;
            m_if_rdata[k] = '0; m_d_rdata[k] = '0; e_if_ready[k] = 0; e_d_ready[k] = 0;
            f_pct[k] = 0; d_pct[k] = 0; f_pend[k] = 0; d_pend[k] = 0;
        end
        #1;
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_latency3();
        test_withdraw();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch port (IF stage) and the data load/store port (MEM stage) of the 5-stage pipeline. It grants one requester at a time and sequences a fixed-latency memory access. It returns read data with a one-cycle ready pulse. Until a request is served, it drives stall signals that the hazard unit ORs into stall_F and the stage-freeze logic.

Parameters:
AW, 9, memory address width
DW, 32, data width
LAT, 1, memory access cycles (must be >= 1)
STARVE_MAX, 4, number of consecutive data wins under contention before fetch is forced to win

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  AW  fetch address (PC)
if_rdata  out  DW  fetched instruction; valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request (MEM-stage E); held until d_ready
d_rw  in  1  1 = write, 0 = read
d_size  in  2  access size, passed through
d_se  in  1  sign extend, passed through
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data; valid while d_ready=1
d_ready  out  1  one-cycle completion pulse for data
mem_en  out  1  memory enable
mem_rw  out  1  memory write
mem_size  out  2  memory size
mem_se  out  1  memory sign extend
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid in last access cycle
stall_if  out  1  if_req & ~if_ready (combinational)
stall_mem  out  1  d_req & ~d_ready (combinational)

Behaviour:
- Reset, applied synchronously on the clk edge with reset=1:
  - state goes to IDLE.
  - All registered outputs go to 0: mem_*, if_rdata, d_rdata, if_ready, d_ready.
  - The latency counter and starve_cnt go to 0.
- Reset asserted mid-access aborts the access. The abort takes effect on the next edge: mem_en=0 and no ready pulse is issued.
- FSM states:
  - IDLE: evaluate the grant.
    - Neither request: stay in IDLE.
    - Otherwise: go to BUSY_I or BUSY_D and load lat_cnt = LAT-1.
    - The winner's address, rw, size, se and wdata are registered onto mem_*, and mem_en=1.
    - A fetch grant forces mem_rw=0 and mem_size=word.
  - BUSY_x: mem_en and the mem_* fields are held stable.
    - If lat_cnt != 0: decrement it.
    - If lat_cnt == 0: capture mem_rdata into the granted port's rdata register, drop mem_en, and go to DONE_x.
  - DONE_x: assert the granted port's ready for exactly one cycle, with rdata valid, then go to IDLE.
    - The other port's rdata register holds its old value.
- Timing:
  - The request is seen in cycle 0.
  - mem_en is high in cycles 1..LAT.
  - The ready pulse occurs in cycle LAT+1.
  - The next arbitration happens in cycle LAT+2. Throughput is one access per LAT+2 cycles.
- Arbitration:
  - Data wins by default.
  - If both requests are high and starve_cnt == STARVE_MAX, fetch wins instead.
  - starve_cnt increments (saturating at STARVE_MAX) only when both requests are high in IDLE and data wins.
  - starve_cnt clears to 0 whenever fetch is granted.
- Request withdrawal: if a requester drops req during BUSY or DONE, the access still completes. A write is never aborted, and the ready pulse is still issued.
- Requesters must keep their address and data stable while req=1 and ready=0. After the ready pulse, the next req seen in IDLE is treated as a new transaction.
- stall_if and stall_mem are purely combinational. They are 0 whenever their req is 0.
- Writes: the data port receives a d_ready pulse. The d_rdata register captures mem_rdata, and its value is don't-care to the consumer.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D
  - grant ID constants: GNT_IF, GNT_D
  - SIZE_WORD constant
  - STARVE_W computed as clog2(STARVE_MAX+1)
- One natural sub-module, mem_lat_counter: loadable down-counter with load, enable, zero flag, sized by LAT. All other logic stays in one FSM module.

Test Plan:
- Lone fetch, LAT=1: if_req=1, if_addr=0x004, mem_rdata=0xA0000001 in cycle 1 -> mem_en high only in cycle 1 with mem_addr=0x004 and mem_rw=0; if_ready=1 in cycle 2 with if_rdata=0xA0000001; stall_if=1 in cycles 0-1 and 0 in cycle 2.
- Contention: if_req and d_req held, d_rw=1, d_addr=0x010, d_wdata=0xDEADBEEF -> data served first with mem_rw=1; d_ready in cycle 2; fetch granted in cycle 3; if_ready in cycle 5; stall_if high in cycles 0-4.
- Starvation guard, STARVE_MAX=4: d_req held continuously with back-to-back new addresses, if_req held -> 4 data accesses, then fetch wins the 5th arbitration, and starve_cnt returns to 0.
- Latency LAT=3: d_req read at 0x020, mem_rdata=0x12345678 in cycle 3 -> mem_en high in cycles 1-3; d_ready in cycle 4 with d_rdata=0x12345678.
- Withdrawal and reset: d_req write dropped in cycle 1 -> mem_en still held for LAT cycles and d_ready still pulses. A separate run with reset=1 in cycle 2 of a LAT=3 read -> cycle 3 has mem_en=0, state IDLE, and no d_ready pulse ever issued.
